// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU operation encodings and the register-match helper
// used by the ID/EX pipeline register and its forwarding muxes.
package id_ex_stage_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 3;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101
  } alu_op_e;

  // r0 is hard-wired zero, so a write to it never counts as a producer.
  function automatic logic reg_hit(input logic             wr_en,
                                   input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] src);
    return wr_en && (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forwarding select: the EX/MEM result beats the MEM/WB
// result, which beats the value captured in the ID/EX register.
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [REG_W-1:0]  src_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_regwrite,
  input  logic [REG_W-1:0]  mem_dst_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_dst_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] fwd_data
);

  always_comb begin
    fwd_data = reg_data;
    if (reg_hit(mem_regwrite, mem_dst_addr, src_addr)) begin
      fwd_data = mem_result;
    end else if (reg_hit(wb_regwrite, wb_dst_addr, src_addr)) begin
      fwd_data = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, WB capture bypass
// and EX-side operand forwarding for rs and rt.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               ID_Valid,
  input  logic [REG_W-1:0]   ID_RsAddr,
  input  logic [REG_W-1:0]   ID_RtAddr,
  input  logic [DATA_W-1:0]  ID_RsData,
  input  logic [DATA_W-1:0]  ID_RtData,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic               ID_ALUSrc,
  input  logic               ID_UsesRt,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic [REG_W-1:0]   ID_DstAddr,
  input  logic               Flush,
  input  logic               Hold,
  input  logic               MEM_RegWrite,
  input  logic [REG_W-1:0]   MEM_DstAddr,
  input  logic [DATA_W-1:0]  MEM_Result,
  input  logic               WB_RegWrite,
  input  logic [REG_W-1:0]   WB_DstAddr,
  input  logic [DATA_W-1:0]  WB_Result,
  output logic               Stall,
  output logic               EX_Valid,
  output logic [DATA_W-1:0]  ALU_DA,
  output logic [DATA_W-1:0]  ALU_DB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [DATA_W-1:0]  EX_StoreData,
  output logic               EX_RegWrite,
  output logic               EX_MemRead,
  output logic               EX_MemWrite,
  output logic [REG_W-1:0]   EX_DstAddr
);

  logic               valid_reg;
  logic [REG_W-1:0]   rs_addr_reg;
  logic [REG_W-1:0]   rt_addr_reg;
  logic [DATA_W-1:0]  rs_data_reg;
  logic [DATA_W-1:0]  rt_data_reg;
  logic [DATA_W-1:0]  imm_reg;
  logic               alusrc_reg;
  logic [ALUOP_W-1:0] aluop_reg;
  logic               regwrite_reg;
  logic               memread_reg;
  logic               memwrite_reg;
  logic [REG_W-1:0]   dst_addr_reg;

  logic               hazard;
  logic [DATA_W-1:0]  rs_data_next;
  logic [DATA_W-1:0]  rt_data_next;
  logic [DATA_W-1:0]  rs_fwd;
  logic [DATA_W-1:0]  rt_fwd;

  // A load in EX whose destination is read by the decode instruction.
  assign hazard = valid_reg && memread_reg && (dst_addr_reg != '0) && ID_Valid &&
                  ((ID_RsAddr == dst_addr_reg) ||
                   (ID_UsesRt && (ID_RtAddr == dst_addr_reg)));

  assign Stall = (hazard || Hold) && !Flush;

  // The register file is read before WB writes it, so bypass WB on capture.
  assign rs_data_next = reg_hit(WB_RegWrite, WB_DstAddr, ID_RsAddr) ? WB_Result : ID_RsData;
  assign rt_data_next = reg_hit(WB_RegWrite, WB_DstAddr, ID_RtAddr) ? WB_Result : ID_RtData;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      rs_addr_reg  <= '0;
      rt_addr_reg  <= '0;
      rs_data_reg  <= '0;
      rt_data_reg  <= '0;
      imm_reg      <= '0;
      alusrc_reg   <= 1'b0;
      aluop_reg    <= ALU_ADD;
      regwrite_reg <= 1'b0;
      memread_reg  <= 1'b0;
      memwrite_reg <= 1'b0;
      dst_addr_reg <= '0;
    end else if (Flush || (!Hold && hazard)) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      memread_reg  <= 1'b0;
      memwrite_reg <= 1'b0;
    end else if (!Hold) begin
      valid_reg    <= ID_Valid;
      rs_addr_reg  <= ID_RsAddr;
      rt_addr_reg  <= ID_RtAddr;
      rs_data_reg  <= rs_data_next;
      rt_data_reg  <= rt_data_next;
      imm_reg      <= ID_Imm;
      alusrc_reg   <= ID_ALUSrc;
      aluop_reg    <= ID_ALUOp;
      regwrite_reg <= ID_RegWrite && ID_Valid;
      memread_reg  <= ID_MemRead && ID_Valid;
      memwrite_reg <= ID_MemWrite && ID_Valid;
      dst_addr_reg <= ID_DstAddr;
    end
  end

  fwd_mux u_fwd_rs (
    .src_addr     (rs_addr_reg),
    .reg_data     (rs_data_reg),
    .mem_regwrite (MEM_RegWrite),
    .mem_dst_addr (MEM_DstAddr),
    .mem_result   (MEM_Result),
    .wb_regwrite  (WB_RegWrite),
    .wb_dst_addr  (WB_DstAddr),
    .wb_result    (WB_Result),
    .fwd_data     (rs_fwd)
  );

  fwd_mux u_fwd_rt (
    .src_addr     (rt_addr_reg),
    .reg_data     (rt_data_reg),
    .mem_regwrite (MEM_RegWrite),
    .mem_dst_addr (MEM_DstAddr),
    .mem_result   (MEM_Result),
    .wb_regwrite  (WB_RegWrite),
    .wb_dst_addr  (WB_DstAddr),
    .wb_result    (WB_Result),
    .fwd_data     (rt_fwd)
  );

  assign EX_Valid     = valid_reg;
  assign ALU_DA       = rs_fwd;
  assign ALU_DB       = alusrc_reg ? imm_reg : rt_fwd;
  assign ALUOp        = aluop_reg;
  assign EX_StoreData = rt_fwd;
  assign EX_RegWrite  = regwrite_reg;
  assign EX_MemRead   = memread_reg;
  assign EX_MemWrite  = memwrite_reg;
  assign EX_DstAddr   = dst_addr_reg;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: none; field widths fixed (data 32, register address 5, ALUOp 3), taken from the shared package.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ID_Valid in 1 decode slot holds an instruction; ID_RsAddr, ID_RtAddr in 5 each, source registers; ID_RsData, ID_RtData in 32 each, register-file read data.
REQ-005 ID_Imm in 32 sign-extended immediate; ID_ALUSrc in 1 (1 = DB from immediate); ID_UsesRt in 1 rt is a real source; ID_ALUOp in 3.
REQ-006 ID_RegWrite, ID_MemRead, ID_MemWrite in 1 each; ID_DstAddr in 5 destination register.
REQ-007 Flush in 1 kill the instruction entering EX; Hold in 1 downstream not accepting.
REQ-008 MEM_RegWrite in 1, MEM_DstAddr in 5, MEM_Result in 32: EX/MEM forwarding source; WB_RegWrite in 1, WB_DstAddr in 5, WB_Result in 32: MEM/WB forwarding source.
REQ-009 Stall out 1 upstream (PC, IF/ID) keeps its contents this cycle.
REQ-010 EX_Valid out 1; ALU_DA, ALU_DB out 32 each, ALU operands; ALUOp out 3; EX_StoreData out 32 forwarded rt value.
REQ-011 EX_RegWrite, EX_MemRead, EX_MemWrite out 1 each; EX_DstAddr out 5.

Function
REQ-012 Register update priority per edge SHALL be: reset > Flush > Hold > load-use bubble > load.
REQ-013 Flush: EX_Valid <= 0 and EX_RegWrite, EX_MemRead, EX_MemWrite <= 0; the other fields are don't-care.
REQ-014 Hold (no Flush): every register keeps its value.
REQ-015 Load-use hazard SHALL be: EX_Valid & EX_MemRead & EX_DstAddr!=0 & ID_Valid & (ID_RsAddr==EX_DstAddr | (ID_UsesRt & ID_RtAddr==EX_DstAddr)).
REQ-016 On a hazard (no Flush, no Hold): insert a bubble (as REQ-013) while the ID instruction waits.
REQ-017 Stall SHALL be combinational: Stall = (hazard | Hold) & ~Flush.
REQ-018 Load: all ID fields are captured and EX_Valid <= ID_Valid; the control bits are ANDed with ID_Valid.
REQ-019 Capture bypass: if WB_RegWrite & WB_DstAddr!=0 & WB_DstAddr==ID_RsAddr (or RtAddr), capture WB_Result in place of the register-file data.
REQ-020 Operand forwarding (combinational, from registered Rs/Rt): MEM match (MEM_RegWrite, MEM_DstAddr!=0, address equal) selects MEM_Result; else a WB match selects WB_Result; else the registered data.
REQ-021 ALU_DB = immediate when the registered ALUSrc=1, else forwarded rt; EX_StoreData is always forwarded rt.
REQ-022 Register 0 is never forwarded or bypassed and never triggers a hazard.
REQ-023 Latency: one cycle from ID capture to EX outputs; throughput is one per cycle absent a hazard or Hold.
REQ-024 A hazard lasts exactly one bubble cycle; a second cycle is impossible, since the load has left EX.

Reset
REQ-025 On reset: all registers 0, so EX_Valid=0, all control outputs 0, ALU_DA=ALU_DB=0 (absent a forwarding match on r0, which is none), ALUOp=000, Stall=Hold.
REQ-026 Reset asserted mid-stall discards the pending bubble; the first cycle after reset loads normally.

Structure
REQ-027 A shared package holds the ALUOp encodings (ADD 000, SUB 001, AND 010, OR 100, XOR 101) and the width constants.
REQ-028 One sub-module, fwd_mux (single-operand forwarding select), is instantiated twice (rs, rt).

Verification
REQ-029 Load ADD r3=r1+r2, ID_RsData=5, ID_RtData=7, no forwarding -> next cycle EX_Valid=1, ALU_DA=5, ALU_DB=7, ALUOp=000.
REQ-030 MEM_DstAddr=1, MEM_Result=0x10 and WB_DstAddr=1, WB_Result=0x20, both RegWrite -> ALU_DA=0x10 (MEM wins); with MEM_RegWrite=0 -> ALU_DA=0x20.
REQ-031 EX holds LW to r4, ID has rs=r4 -> Stall=1 for one cycle; next cycle EX_Valid=0, control bits 0; the following cycle the instruction enters.
REQ-032 Flush and Hold together with ID_Valid=1 -> next cycle EX_Valid=0, Stall=0.
REQ-033 Hold=1 for 3 cycles while MEM_Result changes -> registers are unchanged and ALU_DA follows the forwarding each cycle.
REQ-034 A WB write to r0 with WB_Result=0xFFFF and ID rs=r0, ID_RsData=0 -> ALU_DA=0; a hazard on r0 -> Stall=0.
